// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage: load capture, alignment, hold buffer, WB/ID forwarding
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 94,
    parameter int MS_TO_WS_BUS_WD = 84
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       ms_flush,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [9:0]                 stall_ms_bus,
    output logic [32:0]                forward_ms_bus,
    input  logic [31:0]                data_sram_rdata
);

    logic                       r_ms_valid;
    logic                       r_first_cyc;
    logic                       r_rbuf_valid;
    logic [31:0]                r_rbuf;
    logic [ES_TO_MS_BUS_WD-1:0] r_ms_bus;

    logic [31:0] w_pc;
    logic [31:0] w_alu_result;
    logic [4:0]  w_dest;
    logic        w_gr_we;
    logic [6:0]  w_inst_load;
    logic        w_res_from_mem;
    logic [7:0]  w_cp0_addr;
    logic        w_res_from_cp0;
    logic        w_cp0_wen;
    logic        w_eret_flush;
    logic        w_unused_ld_extd_op;

    assign w_pc                = r_ms_bus[31:0];
    assign w_alu_result        = r_ms_bus[63:32];
    assign w_dest              = r_ms_bus[68:64];
    assign w_gr_we             = r_ms_bus[69];
    assign w_unused_ld_extd_op = ^r_ms_bus[74:70];
    assign w_inst_load         = r_ms_bus[81:75];
    assign w_res_from_mem      = r_ms_bus[82];
    assign w_cp0_addr          = r_ms_bus[90:83];
    assign w_res_from_cp0      = r_ms_bus[91];
    assign w_cp0_wen           = r_ms_bus[92];
    assign w_eret_flush        = r_ms_bus[93];

    logic w_ms_ready_go;
    logic w_accept;
    logic w_leave;
    logic w_hold_capture;

    assign w_ms_ready_go  = 1'b1;
    assign ms_allowin     = !r_ms_valid || (w_ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = r_ms_valid && w_ms_ready_go && !ms_flush;
    assign w_accept       = es_to_ms_valid && ms_allowin;
    assign w_leave        = ms_to_ws_valid && ws_allowin;
    // SRAM data is only presented in the first MEM cycle; keep it if WB stalls us.
    assign w_hold_capture = r_first_cyc && r_ms_valid && w_res_from_mem && !ws_allowin;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ms_valid  <= 1'b0;
            r_first_cyc <= 1'b0;
        end else if (ms_flush) begin
            r_ms_valid  <= 1'b0;
            r_first_cyc <= 1'b0;
        end else if (ms_allowin) begin
            r_ms_valid  <= es_to_ms_valid;
            r_first_cyc <= es_to_ms_valid;
        end else begin
            r_first_cyc <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ms_bus <= '0;
        end else if (w_accept) begin
            r_ms_bus <= es_to_ms_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rbuf_valid <= 1'b0;
            r_rbuf       <= 32'h0;
        end else if (ms_flush || w_leave) begin
            r_rbuf_valid <= 1'b0;
        end else if (w_hold_capture) begin
            r_rbuf_valid <= 1'b1;
            r_rbuf       <= data_sram_rdata;
        end
    end

    logic [31:0] w_ld_data;
    logic [1:0]  w_addr_lo;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_lwl_data;
    logic [31:0] w_lwr_data;
    logic [3:0]  w_lwl_wstrb;
    logic [3:0]  w_lwr_wstrb;
    logic [31:0] w_load_result;
    logic [3:0]  w_load_wstrb;

    assign w_ld_data = r_rbuf_valid ? r_rbuf : data_sram_rdata;
    assign w_addr_lo = w_alu_result[1:0];

    always_comb begin
        w_byte      = w_ld_data[7:0];
        w_lwl_data  = w_ld_data;
        w_lwr_data  = w_ld_data;
        w_lwl_wstrb = 4'b1111;
        w_lwr_wstrb = 4'b1111;
        case (w_addr_lo)
            2'd0: begin
                w_byte      = w_ld_data[7:0];
                w_lwl_data  = {w_ld_data[7:0], 24'h0};
                w_lwr_data  = w_ld_data;
                w_lwl_wstrb = 4'b1000;
                w_lwr_wstrb = 4'b1111;
            end
            2'd1: begin
                w_byte      = w_ld_data[15:8];
                w_lwl_data  = {w_ld_data[15:0], 16'h0};
                w_lwr_data  = {8'h0, w_ld_data[31:8]};
                w_lwl_wstrb = 4'b1100;
                w_lwr_wstrb = 4'b0111;
            end
            2'd2: begin
                w_byte      = w_ld_data[23:16];
                w_lwl_data  = {w_ld_data[23:0], 8'h0};
                w_lwr_data  = {16'h0, w_ld_data[31:16]};
                w_lwl_wstrb = 4'b1110;
                w_lwr_wstrb = 4'b0011;
            end
            default: begin
                w_byte      = w_ld_data[31:24];
                w_lwl_data  = w_ld_data;
                w_lwr_data  = {24'h0, w_ld_data[31:24]};
                w_lwl_wstrb = 4'b1111;
                w_lwr_wstrb = 4'b0001;
            end
        endcase
    end

    // Halfword select ignores a[0]; misaligned halfwords never reach this stage.
    assign w_half = w_addr_lo[1] ? w_ld_data[31:16] : w_ld_data[15:0];

    always_comb begin
        w_load_result = w_ld_data;
        w_load_wstrb  = 4'b1111;
        if (w_inst_load[1]) begin
            w_load_result = {{24{w_byte[7]}}, w_byte};
        end else if (w_inst_load[2]) begin
            w_load_result = {24'h0, w_byte};
        end else if (w_inst_load[3]) begin
            w_load_result = {{16{w_half[15]}}, w_half};
        end else if (w_inst_load[4]) begin
            w_load_result = {16'h0, w_half};
        end else if (w_inst_load[5]) begin
            w_load_result = w_lwl_data;
            w_load_wstrb  = w_lwl_wstrb;
        end else if (w_inst_load[6]) begin
            w_load_result = w_lwr_data;
            w_load_wstrb  = w_lwr_wstrb;
        end
    end

    logic [31:0] w_final_result;
    logic [3:0]  w_rf_wstrb;
    logic        w_fwd_valid;

    assign w_final_result = w_res_from_mem ? w_load_result : w_alu_result;
    assign w_rf_wstrb     = (w_res_from_mem ? w_load_wstrb : 4'b1111) & {4{w_gr_we}};
    // Partial lwl/lwr results need the old register value merged in WB, so they are not forwarded.
    assign w_fwd_valid    = r_ms_valid && !w_res_from_cp0 && !w_inst_load[5] && !w_inst_load[6];

    assign ms_to_ws_bus   = {w_eret_flush, w_cp0_wen, w_res_from_cp0, w_cp0_addr,
                             w_rf_wstrb, w_dest, w_final_result, w_pc};
    assign stall_ms_bus   = {{5{r_ms_valid && w_gr_we}}, w_dest};
    assign forward_ms_bus = {w_fwd_valid, w_final_result};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized and directed self-checking bench for mem_stage
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_allowin;
    logic        es_to_ms_valid;
    logic [93:0] es_to_ms_bus;
    logic        ms_flush;
    logic [31:0] data_sram_rdata;
    logic        ms_allowin;
    logic        ms_to_ws_valid;
    logic [83:0] ms_to_ws_bus;
    logic [9:0]  stall_ms_bus;
    logic [32:0] forward_ms_bus;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .ws_allowin     (ws_allowin),
        .ms_allowin     (ms_allowin),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .ms_flush       (ms_flush),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ms_to_ws_bus   (ms_to_ws_bus),
        .stall_ms_bus   (stall_ms_bus),
        .forward_ms_bus (forward_ms_bus),
        .data_sram_rdata(data_sram_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_xfer = 0;

    task automatic chk_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: the instruction resident in MEM and the word the SRAM returned in its first cycle.
    bit          m_valid = 1'b0;
    bit          m_first = 1'b0;
    logic [93:0] m_bus = '0;
    logic [31:0] m_word = '0;

    bit          dir_res_en = 1'b0;
    logic [31:0] dir_res;
    logic [3:0]  dir_wstrb;
    bit          dir_hs_en = 1'b0;
    bit          dir_vld;
    bit          dir_allowin;

    function automatic logic [93:0] mk_instr(input int kind, input logic [31:0] alu, input bit gr);
        logic [6:0] ld;
        ld = '0;
        if (kind < 7) ld[kind] = 1'b1;
        return {1'($urandom), 1'($urandom), 1'(kind == 8), 8'($urandom), 1'(kind < 7), ld,
                5'($urandom), gr, 5'($urandom), alu, 32'($urandom)};
    endfunction

    function automatic logic [93:0] rand_instr();
        int kind;
        bit gr;
        kind = $urandom_range(0, 9);
        gr = (kind == 9) ? 1'b0 : ($urandom_range(0, 7) != 0);
        return mk_instr(kind, 32'($urandom), gr);
    endfunction

    // Returns {wstrb, result} computed from the load rules with plain arithmetic.
    function automatic logic [35:0] ref_wb(input logic [93:0] b, input logic [31:0] d);
        logic [31:0] alu, r, v;
        logic [3:0]  w;
        logic [6:0]  ld;
        logic [3:0]  lwl_t [4];
        logic [3:0]  lwr_t [4];
        int          ai;
        lwl_t = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
        lwr_t = '{4'b1111, 4'b0111, 4'b0011, 4'b0001};
        alu = b[63:32];
        ai  = int'(alu[1:0]);
        ld  = b[81:75];
        r   = alu;
        w   = 4'hF;
        if (b[82]) begin
            if (ld[1] || ld[2]) begin
                v = (d >> (8 * ai)) & 32'hFF;
                if (ld[1] && v >= 32'd128) v = v | 32'hFFFF_FF00;
                r = v;
            end else if (ld[3] || ld[4]) begin
                v = (d >> (16 * (ai / 2))) & 32'hFFFF;
                if (ld[3] && v >= 32'd32768) v = v | 32'hFFFF_0000;
                r = v;
            end else if (ld[5]) begin
                r = d << (8 * (3 - ai));
                w = lwl_t[ai];
            end else if (ld[6]) begin
                r = d >> (8 * ai);
                w = lwr_t[ai];
            end else begin
                r = d;
            end
        end
        w = w & {4{b[69]}};
        return {w, r};
    endfunction

    task automatic set_in(input bit v, input logic [93:0] b, input logic [31:0] rd,
                          input bit wsa, input bit fl, input bit rn);
        es_to_ms_valid  = v;
        es_to_ms_bus    = b;
        data_sram_rdata = rd;
        ws_allowin      = wsa;
        ms_flush        = fl;
        resetn          = rn;
        dir_res_en      = 1'b0;
        dir_hs_en       = 1'b0;
    endtask

    task automatic step();
        logic [35:0] wr;
        bit          fwd;
        bit          exp_vld;
        @(negedge clk);
        if (m_valid && m_first) m_word = data_sram_rdata;
        exp_vld = m_valid && !ms_flush;
        chk_eq("allowin", 96'(ms_allowin), 96'(!m_valid || ws_allowin));
        chk_eq("to_ws_valid", 96'(ms_to_ws_valid), 96'(exp_vld));
        chk_eq("stall_we", 96'(stall_ms_bus[9:5]), 96'({5{m_valid && m_bus[69]}}));
        fwd = m_valid && !m_bus[91] && !m_bus[80] && !m_bus[81];
        chk_eq("fwd_valid", 96'(forward_ms_bus[32]), 96'(fwd));
        if (m_valid) begin
            wr = ref_wb(m_bus, m_word);
            chk_eq("ws_bus", 96'(ms_to_ws_bus),
                   96'({m_bus[93], m_bus[92], m_bus[91], m_bus[90:83], wr[35:32],
                        m_bus[68:64], wr[31:0], m_bus[31:0]}));
            chk_eq("fwd_data", 96'(forward_ms_bus[31:0]), 96'(wr[31:0]));
            chk_eq("stall_dest", 96'(stall_ms_bus[4:0]), 96'(m_bus[68:64]));
            if (exp_vld && ws_allowin) n_xfer++;
        end
        if (dir_res_en) begin
            chk_eq("dir_result", 96'(ms_to_ws_bus[63:32]), 96'(dir_res));
            chk_eq("dir_wstrb", 96'(ms_to_ws_bus[72:69]), 96'(dir_wstrb));
        end
        if (dir_hs_en) begin
            chk_eq("dir_valid", 96'(ms_to_ws_valid), 96'(dir_vld));
            chk_eq("dir_allowin", 96'(ms_allowin), 96'(dir_allowin));
        end
        @(posedge clk);
        #1;
        if (!resetn || ms_flush) begin
            m_valid = 1'b0;
            m_first = 1'b0;
        end else if (!m_valid || ws_allowin) begin
            m_valid = es_to_ms_valid;
            m_first = es_to_ms_valid;
            if (es_to_ms_valid) m_bus = es_to_ms_bus;
        end else begin
            m_first = 1'b0;
        end
    endtask

    initial begin
        set_in(0, '0, 32'h0, 1, 0, 0);
        dir_hs_en = 1; dir_vld = 0; dir_allowin = 1;
        step();
        set_in(0, '0, 32'h0, 1, 0, 1);
        step();

        // reset while a stalled load holds its buffered data
        set_in(1, mk_instr(0, 32'h100, 1), 32'h0, 1, 0, 1);           step();
        set_in(0, '0, 32'h1111_1111, 0, 0, 1);                        step();
        set_in(0, '0, 32'h2222_2222, 0, 0, 1);                        step();
        set_in(0, '0, 32'h3333_3333, 0, 0, 0);                        step();
        set_in(0, '0, 32'h4444_4444, 0, 0, 1);
        dir_hs_en = 1; dir_vld = 0; dir_allowin = 1;                  step();
        set_in(1, mk_instr(0, 32'h104, 1), 32'h0, 1, 0, 1);           step();
        set_in(0, '0, 32'hA5A5_5A5A, 1, 0, 1);
        dir_res_en = 1; dir_res = 32'hA5A5_5A5A; dir_wstrb = 4'hF;    step();

        // lb / lbu at byte 3
        set_in(1, mk_instr(1, 32'h1000_0003, 1), 32'h0, 1, 0, 1);     step();
        set_in(0, '0, 32'h80FF_FF7F, 1, 0, 1);
        dir_res_en = 1; dir_res = 32'hFFFF_FF80; dir_wstrb = 4'hF;    step();
        set_in(1, mk_instr(2, 32'h1000_0003, 1), 32'h0, 1, 0, 1);     step();
        set_in(0, '0, 32'h80FF_FF7F, 1, 0, 1);
        dir_res_en = 1; dir_res = 32'h0000_0080; dir_wstrb = 4'hF;    step();

        // lwl a=1, lwr a=2
        set_in(1, mk_instr(5, 32'h2000_0001, 1), 32'h0, 1, 0, 1);     step();
        set_in(0, '0, 32'h1122_3344, 1, 0, 1);
        dir_res_en = 1; dir_res = 32'h3344_0000; dir_wstrb = 4'b1100; step();
        set_in(1, mk_instr(6, 32'h2000_0002, 1), 32'h0, 1, 0, 1);     step();
        set_in(0, '0, 32'h1122_3344, 1, 0, 1);
        dir_res_en = 1; dir_res = 32'h0000_1122; dir_wstrb = 4'b0011; step();

        // lw held across three stalled cycles
        set_in(1, mk_instr(0, 32'h3000_0000, 1), 32'h0, 1, 0, 1);     step();
        set_in(0, '0, 32'h1234_5678, 0, 0, 1);
        dir_res_en = 1; dir_res = 32'h1234_5678; dir_wstrb = 4'hF;    step();
        for (int i = 0; i < 2; i++) begin
            set_in(0, '0, 32'hDEAD_BEEF, 0, 0, 1);
            dir_res_en = 1; dir_res = 32'h1234_5678; dir_wstrb = 4'hF; step();
        end
        set_in(0, '0, 32'hDEAD_BEEF, 1, 0, 1);
        dir_res_en = 1; dir_res = 32'h1234_5678; dir_wstrb = 4'hF;    step();
        set_in(1, mk_instr(0, 32'h3000_0004, 1), 32'h0, 1, 0, 1);     step();
        set_in(0, '0, 32'h0BAD_F00D, 0, 0, 1);
        dir_res_en = 1; dir_res = 32'h0BAD_F00D; dir_wstrb = 4'hF;    step();
        set_in(0, '0, 32'h0, 1, 0, 1);                                step();

        // flush coinciding with an accept
        set_in(1, mk_instr(7, 32'h4444_0000, 1), 32'h0, 1, 1, 1);     step();
        set_in(0, '0, 32'h0, 1, 0, 1);
        dir_hs_en = 1; dir_vld = 0; dir_allowin = 1;                  step();

        // back-to-back ALU ops
        n_xfer = 0;
        for (int i = 0; i < 4; i++) begin
            set_in(1, mk_instr((i % 2 == 0) ? 7 : 9, 32'($urandom), (i % 2 == 0)), 32'($urandom), 1, 0, 1);
            step();
        end
        set_in(0, '0, 32'h0, 1, 0, 1);                                step();
        chk_eq("b2b_xfer", 96'(n_xfer), 96'd4);

        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 99) < 70, rand_instr(), 32'($urandom),
                   $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 4,
                   $urandom_range(0, 99) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
